map_table: RTL and testbench
============================

# map_table

Rename-stage register map table. It sits between the free list and dispatch. Each cycle it takes up to `WAY` decoded instructions and the new PRs the free list granted that cycle, then emits registered T, Told, T1 and T2 tags with ready bits to the ROB/RS. It tracks per-PR readiness from CDB broadcasts and restores mappings from ROB Told values on rewind.

## Interface
- `WAY`, 3: rename width; same value as the global `` `WAY ``.
- `ARCH_REGS`, 32: architectural registers; R0 is hardwired.
- `PHY_REGS`, 64: physical registers; PR0 is hardwired zero and always ready.
- `clock`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0).
- `stall`  in  1  dispatch back-pressure; the rename group is dropped this cycle.
- `num_to_dispatch`  in  $clog2(WAY+1)  valid slots, from slot 0 upward; already limited by the free list's free_reg_valid.
- `arch_dest_reg`, `arch_src1`, `arch_src2`  in  WAY×5  architectural indices per slot.
- `free_reg`  in  WAY×6  PRs granted by the free list this cycle; 0 for slots with dest R0.
- `cdb_valid`  in  WAY  complete-stage broadcast valid.
- `cdb_tag`  in  WAY×6  completed PRs.
- `rewind_num`  in  $clog2(WAY+1)  entries rewound this cycle; nonzero means rewind.
- `rewind_arch`  in  WAY×5  arch dest of each rewound entry; slot 0 is oldest.
- `rewind_Told`  in  WAY×6  Told of each rewound entry.
- `out_valid`  out  WAY  registered slot valids.
- `T`, `Told`, `T1`, `T2`  out  WAY×6  registered rename tags.
- `T1_ready`, `T2_ready`  out  WAY  registered source-ready bits.

## Operation
- State:
  - `map[ARCH_REGS]` of PR indices.
  - `ready_vec[PHY_REGS]`.
  - The output register bank.
- Rename happens when `rewind_num==0 && !stall`. For slot i < `num_to_dispatch`:
  - Sources: T1/T2 = map[src]. If an earlier slot j<i in the group has a nonzero dest equal to src, use that slot's `free_reg[j]` instead; the youngest such j wins.
  - Source ready = ready_vec[tag] OR any `cdb_valid[k]` with `cdb_tag[k]==tag`. A tag bypassed from within the group is never ready. A source of R0 gives tag 0, ready 1.
  - Told = map[dest], with the same intra-group override as sources. T = `free_reg[i]`.
  - Dest R0: T=0, Told=0, no table write.
  - Table write: map[dest]=free_reg[i] and ready_vec[free_reg[i]]=0. When several slots write the same dest, the highest slot wins.
- CDB: every valid `cdb_tag` sets its ready_vec bit. Tag 0 is ignored.
- Rewind (`rewind_num!=0`):
  - Dispatch inputs are ignored and `out_valid` is 0 next cycle.
  - Entries are applied from i=WAY-1 down to 0, skipping entries with `rewind_arch==0`: map[rewind_arch[i]]=rewind_Told[i]. Slot 0 (oldest) wins on a conflict.
  - ready_vec is not modified by rewind.
- Same-cycle CDB and allocation of the same PR: illegal. An assertion fires.
- Stall: no map or ready_vec update other than CDB; `out_valid` is 0 next cycle.

## Timing
- Inputs are sampled at posedge. Outputs appear one cycle later. Table state is visible to rename in the next cycle.
- Reset (async, on `reset`==0):
  - map[i]=i; ready_vec all 1.
  - `out_valid`=0; T, Told, T1, T2 = 0; T1_ready, T2_ready = 0.
  - Deassertion is synchronised externally.
- Reset asserted mid-group discards the group. The free list resets in the same cycle.
- CDB arriving the same cycle as rename is visible in the registered ready bits. CDB arriving the cycle after is the RS's responsibility.

## Configuration
- `MAP_TABLE_DEBUG_EN`:
  - Defined: adds outputs `dbg_map` (ARCH_REGS×6) and `dbg_ready` (PHY_REGS). Also compiles in assertions:
    - no nonzero PR mapped by two arch registers;
    - map[0]==0;
    - CDB/allocation collision.
  - Undefined: no debug ports and no assertions. Functional behaviour is identical.

## Structure
- Shared header `rename.svh` holds `phy_reg_idx_t`, `arch_reg_idx_t`, `` `WAY ``, `` `PHY_REG_NUM `` and `` `ARCH_REG_NUM ``. These are common with the free list and ROB.
- One sub-module, `map_table_group_bypass`: the combinational intra-group dependency resolver. It takes slot dests, sources and free_regs and returns override tags plus hit flags.

## Test plan
- After reset, rename R1←R2+R3 with free_reg 32 -> T=32, Told=1, T1=2, T2=3, both ready. Next cycle map[1]=32 and ready_vec[32]=0.
- Group: slot0 R5←…, free 33; slot1 R6←R5+R5, free 34 -> slot1 T1=T2=33 not ready, Told=6. Slot1 writing R5 as well gives Told=33.
- Rename R4←R7 while a CDB broadcasts PR 7 -> T1=7, T1_ready=1. With PR 40 unready and CDB 40, a source mapped to 40 -> ready=1.
- Dest R0 slot (store) between two renames -> T=0, Told=0, map unchanged; neighbouring slots still receive free_reg values.
- Rename R1 to 32 then R1 to 35; rewind with rewind_num=2, arch {1,1}, Told {1,32} (slot0 oldest) -> map[1]=1, dispatch ignored, out_valid=0.
- Reset asserted mid-stream with valid outputs -> `out_valid` drops immediately, map is identity, dbg_ready is all ones.

Source files
------------

// File: rtl/map_table_pkg.sv
// Shared rename types and sizes: physical/architectural register indices and group width.
// Used by the map table and by the free list and ROB that sit around it.
package map_table_pkg;

    localparam int WAY       = 3;
    localparam int ARCH_REGS = 32;
    localparam int PHY_REGS  = 64;
    localparam int ARCH_W    = $clog2(ARCH_REGS);
    localparam int PHY_W     = $clog2(PHY_REGS);
    localparam int CNT_W     = $clog2(WAY + 1);

    typedef logic [PHY_W-1:0]  phy_reg_idx_t;
    typedef logic [ARCH_W-1:0] arch_reg_idx_t;
    typedef logic [CNT_W-1:0]  slot_cnt_t;

    // Slots are filled from slot 0 upward, so a count becomes a thermometer mask.
    function automatic logic [WAY-1:0] count_to_mask(slot_cnt_t n);
        logic [WAY-1:0] m;
        m = '0;
        for (int i = 0; i < WAY; i++) begin
            m[i] = (slot_cnt_t'(i) < n);
        end
        return m;
    endfunction

endpackage

// File: rtl/map_table_if.sv
// Rename-group, CDB, rewind and dispatch-output bundle for the map table.
// master = the rename/dispatch side driving groups; slave = the map table.
interface map_table_if;
    import map_table_pkg::*;

    logic                          stall;
    slot_cnt_t                     num_to_dispatch;
    arch_reg_idx_t [WAY-1:0]       arch_dest_reg;
    arch_reg_idx_t [WAY-1:0]       arch_src1;
    arch_reg_idx_t [WAY-1:0]       arch_src2;
    phy_reg_idx_t  [WAY-1:0]       free_reg;
    logic          [WAY-1:0]       cdb_valid;
    phy_reg_idx_t  [WAY-1:0]       cdb_tag;
    slot_cnt_t                     rewind_num;
    arch_reg_idx_t [WAY-1:0]       rewind_arch;
    phy_reg_idx_t  [WAY-1:0]       rewind_Told;
    logic          [WAY-1:0]       out_valid;
    phy_reg_idx_t  [WAY-1:0]       T;
    phy_reg_idx_t  [WAY-1:0]       Told;
    phy_reg_idx_t  [WAY-1:0]       T1;
    phy_reg_idx_t  [WAY-1:0]       T2;
    logic          [WAY-1:0]       T1_ready;
    logic          [WAY-1:0]       T2_ready;

    modport master (
        output stall, num_to_dispatch, arch_dest_reg, arch_src1, arch_src2, free_reg,
               cdb_valid, cdb_tag, rewind_num, rewind_arch, rewind_Told,
        input  out_valid, T, Told, T1, T2, T1_ready, T2_ready
    );

    modport slave (
        input  stall, num_to_dispatch, arch_dest_reg, arch_src1, arch_src2, free_reg,
               cdb_valid, cdb_tag, rewind_num, rewind_arch, rewind_Told,
        output out_valid, T, Told, T1, T2, T1_ready, T2_ready
    );

endinterface

// File: rtl/map_table_group_bypass.sv
// Intra-group dependency resolver: finds, for each slot, the youngest earlier slot
// in the same group whose nonzero dest matches a source or the slot's own dest.
module map_table_group_bypass
    import map_table_pkg::*;
(
    input  logic          [WAY-1:0] slot_valid,
    input  arch_reg_idx_t [WAY-1:0] dest,
    input  arch_reg_idx_t [WAY-1:0] src1,
    input  arch_reg_idx_t [WAY-1:0] src2,
    input  phy_reg_idx_t  [WAY-1:0] free_reg,
    output logic          [WAY-1:0] src1_hit,
    output logic          [WAY-1:0] src2_hit,
    output logic          [WAY-1:0] told_hit,
    output phy_reg_idx_t  [WAY-1:0] src1_tag,
    output phy_reg_idx_t  [WAY-1:0] src2_tag,
    output phy_reg_idx_t  [WAY-1:0] told_tag
);

    // Ascending scan so a later (younger) producer overwrites an earlier one.
    always_comb begin
        src1_hit = '0;
        src2_hit = '0;
        told_hit = '0;
        src1_tag = '0;
        src2_tag = '0;
        told_tag = '0;
        for (int i = 1; i < WAY; i++) begin
            for (int j = 0; j < WAY; j++) begin
                if (j < i && slot_valid[j] && dest[j] != '0) begin
                    if (dest[j] == src1[i]) begin
                        src1_hit[i] = 1'b1;
                        src1_tag[i] = free_reg[j];
                    end
                    if (dest[j] == src2[i]) begin
                        src2_hit[i] = 1'b1;
                        src2_tag[i] = free_reg[j];
                    end
                    if (dest[j] == dest[i]) begin
                        told_hit[i] = 1'b1;
                        told_tag[i] = free_reg[j];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/map_table.sv
// Rename-stage register map table with per-PR ready tracking and ROB-driven rewind.
// Define MAP_TABLE_DEBUG_EN to expose dbg_map/dbg_ready and compile in consistency assertions.
module map_table
    import map_table_pkg::*;
(
    input  logic                          clock,
    input  logic                          reset,
`ifdef MAP_TABLE_DEBUG_EN
    output phy_reg_idx_t [ARCH_REGS-1:0]  dbg_map,
    output logic         [PHY_REGS-1:0]   dbg_ready,
`endif
    map_table_if.slave                    bus
);

    phy_reg_idx_t [ARCH_REGS-1:0] map_q, map_d;
    logic         [PHY_REGS-1:0]  ready_q, ready_d, ready_cdb;
    logic         [WAY-1:0]       out_valid_q, out_valid_d;
    phy_reg_idx_t [WAY-1:0]       t_q, t_d, told_q, told_d, t1_q, t1_d, t2_q, t2_d;
    logic         [WAY-1:0]       t1_ready_q, t1_ready_d, t2_ready_q, t2_ready_d;

    logic                         rename_en;
    logic         [WAY-1:0]       slot_valid;
    logic         [WAY-1:0]       src1_hit, src2_hit, told_hit;
    phy_reg_idx_t [WAY-1:0]       src1_tag, src2_tag, told_tag;

    assign rename_en  = (bus.rewind_num == '0) && !bus.stall;
    assign slot_valid = rename_en ? count_to_mask(bus.num_to_dispatch) : '0;

    map_table_group_bypass u_bypass (
        .slot_valid (slot_valid),
        .dest       (bus.arch_dest_reg),
        .src1       (bus.arch_src1),
        .src2       (bus.arch_src2),
        .free_reg   (bus.free_reg),
        .src1_hit   (src1_hit),
        .src2_hit   (src2_hit),
        .told_hit   (told_hit),
        .src1_tag   (src1_tag),
        .src2_tag   (src2_tag),
        .told_tag   (told_tag)
    );

    // Same-cycle CDB results count as ready, both for the table and for the outputs.
    always_comb begin
        ready_cdb = ready_q;
        for (int k = 0; k < WAY; k++) begin
            if (bus.cdb_valid[k] && bus.cdb_tag[k] != '0) begin
                ready_cdb[bus.cdb_tag[k]] = 1'b1;
            end
        end
    end

    always_comb begin
        out_valid_d = slot_valid;
        t_d    = '0;
        told_d = '0;
        t1_d   = '0;
        t2_d   = '0;
        for (int i = 0; i < WAY; i++) begin
            if (slot_valid[i]) begin
                if (bus.arch_dest_reg[i] != '0) begin
                    t_d[i]    = bus.free_reg[i];
                    told_d[i] = told_hit[i] ? told_tag[i] : map_q[bus.arch_dest_reg[i]];
                end
                if (bus.arch_src1[i] != '0) begin
                    t1_d[i] = src1_hit[i] ? src1_tag[i] : map_q[bus.arch_src1[i]];
                end
                if (bus.arch_src2[i] != '0) begin
                    t2_d[i] = src2_hit[i] ? src2_tag[i] : map_q[bus.arch_src2[i]];
                end
            end
        end
    end

    // A tag produced inside the group has not executed yet, so it is never ready.
    always_comb begin
        t1_ready_d = '0;
        t2_ready_d = '0;
        for (int i = 0; i < WAY; i++) begin
            if (slot_valid[i]) begin
                t1_ready_d[i] = (bus.arch_src1[i] == '0) ||
                                (!src1_hit[i] && ready_cdb[t1_d[i]]);
                t2_ready_d[i] = (bus.arch_src2[i] == '0) ||
                                (!src2_hit[i] && ready_cdb[t2_d[i]]);
            end
        end
    end

    // Rewind walks youngest to oldest so the oldest Told is what survives.
    always_comb begin
        map_d   = map_q;
        ready_d = ready_cdb;
        if (bus.rewind_num != '0) begin
            for (int i = WAY - 1; i >= 0; i--) begin
                if (slot_cnt_t'(i) < bus.rewind_num && bus.rewind_arch[i] != '0) begin
                    map_d[bus.rewind_arch[i]] = bus.rewind_Told[i];
                end
            end
        end else begin
            for (int i = 0; i < WAY; i++) begin
                if (slot_valid[i] && bus.arch_dest_reg[i] != '0) begin
                    map_d[bus.arch_dest_reg[i]] = bus.free_reg[i];
                    ready_d[bus.free_reg[i]]    = 1'b0;
                end
            end
        end
        ready_d[0] = 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                map_q[i] <= phy_reg_idx_t'(i);
            end
            ready_q     <= '1;
            out_valid_q <= '0;
            t_q         <= '0;
            told_q      <= '0;
            t1_q        <= '0;
            t2_q        <= '0;
            t1_ready_q  <= '0;
            t2_ready_q  <= '0;
        end else begin
            map_q       <= map_d;
            ready_q     <= ready_d;
            out_valid_q <= out_valid_d;
            t_q         <= t_d;
            told_q      <= told_d;
            t1_q        <= t1_d;
            t2_q        <= t2_d;
            t1_ready_q  <= t1_ready_d;
            t2_ready_q  <= t2_ready_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.T         = t_q;
    assign bus.Told      = told_q;
    assign bus.T1        = t1_q;
    assign bus.T2        = t2_q;
    assign bus.T1_ready  = t1_ready_q;
    assign bus.T2_ready  = t2_ready_q;

`ifdef MAP_TABLE_DEBUG_EN
    assign dbg_map   = map_q;
    assign dbg_ready = ready_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            assert (map_q[0] == '0);
            for (int i = 0; i < ARCH_REGS; i++) begin
                for (int j = i + 1; j < ARCH_REGS; j++) begin
                    assert (map_q[i] == '0 || map_q[i] != map_q[j]);
                end
            end
            for (int k = 0; k < WAY; k++) begin
                for (int i = 0; i < WAY; i++) begin
                    assert (!(bus.cdb_valid[k] && bus.cdb_tag[k] != '0 && slot_valid[i] &&
                              bus.arch_dest_reg[i] != '0 && bus.cdb_tag[k] == bus.free_reg[i]));
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_map_table.sv
// Directed-vector bench for map_table: stimulus pushes expected rename groups into a
// scoreboard queue and an independent monitor compares them against the registered outputs.
module tb_map_table;
    import map_table_pkg::*;

    typedef struct packed {
        logic [WAY-1:0]        mask;
        logic [WAY-1:0][5:0]   t;
        logic [WAY-1:0][5:0]   told;
        logic [WAY-1:0][5:0]   t1;
        logic [WAY-1:0][5:0]   t2;
        logic [WAY-1:0]        r1;
        logic [WAY-1:0]        r2;
    } exp_t;

    logic clock;
    logic reset;
    int   check_cnt;
    int   pass_cnt;
    exp_t cur_exp;
    exp_t mon_exp;
    exp_t exp_q[$];

    map_table_if mt_if ();

    map_table dut (
        .clock (clock),
        .reset (reset),
        .bus   (mt_if.slave)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        check_cnt++;
        if (actual == expected) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic clearInputs();
        mt_if.stall           = 1'b0;
        mt_if.num_to_dispatch = '0;
        mt_if.arch_dest_reg   = '0;
        mt_if.arch_src1       = '0;
        mt_if.arch_src2       = '0;
        mt_if.free_reg        = '0;
        mt_if.cdb_valid       = '0;
        mt_if.cdb_tag         = '0;
        mt_if.rewind_num      = '0;
        mt_if.rewind_arch     = '0;
        mt_if.rewind_Told     = '0;
    endtask

    task automatic setSlot(input int i, input int dest, input int s1, input int s2, input int fr);
        mt_if.arch_dest_reg[i] = arch_reg_idx_t'(dest);
        mt_if.arch_src1[i]     = arch_reg_idx_t'(s1);
        mt_if.arch_src2[i]     = arch_reg_idx_t'(s2);
        mt_if.free_reg[i]      = phy_reg_idx_t'(fr);
    endtask

    task automatic expSlot(input int i, input int t, input int told,
                           input int t1, input int r1, input int t2, input int r2);
        cur_exp.mask[i] = 1'b1;
        cur_exp.t[i]    = 6'(t);
        cur_exp.told[i] = 6'(told);
        cur_exp.t1[i]   = 6'(t1);
        cur_exp.r1[i]   = r1[0];
        cur_exp.t2[i]   = 6'(t2);
        cur_exp.r2[i]   = r2[0];
    endtask

    // Inputs are held across one posedge; the expectation for that edge is queued after it.
    task automatic applyStimulus();
        @(posedge clock);
        exp_q.push_back(cur_exp);
        #1;
        cur_exp = '0;
        clearInputs();
    endtask

    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                if (exp_q.size() > 0) begin
                    mon_exp = exp_q.pop_front();
                    checkOutput("out_valid", int'(mt_if.out_valid), int'(mon_exp.mask));
                    for (int i = 0; i < WAY; i++) begin
                        if (mon_exp.mask[i]) begin
                            checkOutput($sformatf("s%0d.T", i),    int'(mt_if.T[i]),        int'(mon_exp.t[i]));
                            checkOutput($sformatf("s%0d.Told", i), int'(mt_if.Told[i]),     int'(mon_exp.told[i]));
                            checkOutput($sformatf("s%0d.T1", i),   int'(mt_if.T1[i]),       int'(mon_exp.t1[i]));
                            checkOutput($sformatf("s%0d.T1r", i),  int'(mt_if.T1_ready[i]), int'(mon_exp.r1[i]));
                            checkOutput($sformatf("s%0d.T2", i),   int'(mt_if.T2[i]),       int'(mon_exp.t2[i]));
                            checkOutput($sformatf("s%0d.T2r", i),  int'(mt_if.T2_ready[i]), int'(mon_exp.r2[i]));
                        end
                    end
                end else if (mt_if.out_valid != '0) begin
                    checkOutput("unexpected_valid", int'(mt_if.out_valid), 0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        check_cnt = 0;
        pass_cnt  = 0;
        cur_exp   = '0;
        reset     = 1'b0;
        clearInputs();
        #3;
        checkOutput("rst_out_valid", int'(mt_if.out_valid), 0);
        checkOutput("rst_T",         int'(mt_if.T),         0);
        checkOutput("rst_Told",      int'(mt_if.Told),      0);
        checkOutput("rst_T1",        int'(mt_if.T1),        0);
        checkOutput("rst_T2",        int'(mt_if.T2),        0);
        checkOutput("rst_T1_ready",  int'(mt_if.T1_ready),  0);
        checkOutput("rst_T2_ready",  int'(mt_if.T2_ready),  0);
        #14;
        reset = 1'b1;

        mt_if.num_to_dispatch = 2'd1;
        setSlot(0, 1, 2, 3, 32);
        expSlot(0, 32, 1, 2, 1, 3, 1);
        applyStimulus();

        mt_if.num_to_dispatch = 2'd2;
        setSlot(0, 5, 0, 0, 33);
        setSlot(1, 6, 5, 5, 34);
        expSlot(0, 33, 5, 0, 1, 0, 1);
        expSlot(1, 34, 6, 33, 0, 33, 0);
        applyStimulus();

        mt_if.num_to_dispatch = 2'd3;
        setSlot(0, 7, 1, 6, 35);
        setSlot(1, 5, 7, 0, 36);
        setSlot(2, 5, 5, 2, 37);
        expSlot(0, 35, 7, 32, 0, 34, 0);
        expSlot(1, 36, 33, 35, 0, 0, 1);
        expSlot(2, 37, 36, 36, 0, 2, 1);
        applyStimulus();

        mt_if.num_to_dispatch = 2'd1;
        setSlot(0, 8, 5, 7, 38);
        mt_if.cdb_valid  = 3'b001;
        mt_if.cdb_tag[0] = 6'd37;
        expSlot(0, 38, 8, 37, 1, 35, 0);
        applyStimulus();

        mt_if.num_to_dispatch = 2'd3;
        setSlot(0, 4, 9, 7, 39);
        setSlot(1, 0, 4, 8, 0);
        setSlot(2, 10, 5, 0, 40);
        mt_if.cdb_valid  = 3'b011;
        mt_if.cdb_tag[0] = 6'd35;
        mt_if.cdb_tag[1] = 6'd9;
        expSlot(0, 39, 4, 9, 1, 35, 1);
        expSlot(1, 0, 0, 39, 0, 38, 0);
        expSlot(2, 40, 10, 37, 1, 0, 1);
        applyStimulus();

        mt_if.num_to_dispatch = 2'd1;
        setSlot(0, 11, 7, 10, 41);
        mt_if.cdb_valid  = 3'b001;
        mt_if.cdb_tag[0] = 6'd40;
        expSlot(0, 41, 11, 35, 1, 40, 1);
        applyStimulus();

        mt_if.stall           = 1'b1;
        mt_if.num_to_dispatch = 2'd1;
        setSlot(0, 12, 0, 0, 42);
        mt_if.cdb_valid  = 3'b001;
        mt_if.cdb_tag[0] = 6'd41;
        applyStimulus();

        mt_if.num_to_dispatch = 2'd1;
        setSlot(0, 12, 11, 12, 42);
        expSlot(0, 42, 12, 41, 1, 12, 1);
        applyStimulus();

        mt_if.num_to_dispatch = 2'd1;
        setSlot(0, 1, 0, 0, 43);
        expSlot(0, 43, 32, 0, 1, 0, 1);
        applyStimulus();

        mt_if.rewind_num      = 2'd2;
        mt_if.rewind_arch[0]  = 5'd1;
        mt_if.rewind_Told[0]  = 6'd1;
        mt_if.rewind_arch[1]  = 5'd1;
        mt_if.rewind_Told[1]  = 6'd32;
        mt_if.rewind_arch[2]  = 5'd3;
        mt_if.rewind_Told[2]  = 6'd50;
        mt_if.num_to_dispatch = 2'd1;
        setSlot(0, 2, 0, 0, 44);
        applyStimulus();

        mt_if.num_to_dispatch = 2'd3;
        setSlot(0, 13, 1, 3, 45);
        setSlot(1, 2, 2, 0, 46);
        setSlot(2, 1, 13, 1, 47);
        expSlot(0, 45, 13, 1, 1, 3, 1);
        expSlot(1, 46, 2, 2, 1, 0, 1);
        expSlot(2, 47, 1, 45, 0, 1, 1);
        applyStimulus();

        mt_if.num_to_dispatch = 2'd1;
        setSlot(0, 14, 0, 0, 48);
        setSlot(1, 15, 0, 0, 49);
        expSlot(0, 48, 14, 0, 1, 0, 1);
        applyStimulus();

        mt_if.num_to_dispatch = 2'd2;
        setSlot(0, 15, 14, 0, 49);
        setSlot(1, 0, 0, 0, 0);
        expSlot(0, 49, 15, 48, 0, 0, 1);
        expSlot(1, 0, 0, 0, 1, 0, 1);
        applyStimulus();

        mt_if.num_to_dispatch = 2'd2;
        setSlot(0, 16, 0, 0, 50);
        setSlot(1, 17, 16, 0, 51);
        expSlot(0, 50, 16, 0, 1, 0, 1);
        expSlot(1, 51, 17, 50, 0, 0, 1);
        applyStimulus();

        @(negedge clock);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("midrst_out_valid", int'(mt_if.out_valid), 0);
        checkOutput("midrst_T",         int'(mt_if.T),         0);
        @(posedge clock);
        #1;
        reset = 1'b1;

        mt_if.num_to_dispatch = 2'd3;
        setSlot(0, 1, 1, 16, 32);
        setSlot(1, 17, 17, 5, 33);
        setSlot(2, 0, 1, 0, 0);
        expSlot(0, 32, 1, 1, 1, 16, 1);
        expSlot(1, 33, 17, 17, 1, 5, 1);
        expSlot(2, 0, 0, 32, 0, 0, 1);
        applyStimulus();

        repeat (2) @(posedge clock);
        #1;
        checkOutput("sb_drain", exp_q.size(), 0);
        $display("[TB] %0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
